// File: rtl/dual_port_ram_be.sv
// True dual-port word RAM with byte-lane write enables, selectable read-during-write
// behaviour, 1/2-cycle read latency with valid strobe and a post-reset clear sequencer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE_RST | in or just out of reset; busy follows init_clear
// CLEAR    | writing zero to mem[r_clr_cnt], one word per cycle
// READY    | normal operation, both ports accept requests
module dual_port_ram_be #(
    parameter int addr_width   = 10,
    parameter int data_width   = 32,
    parameter int rd_mode      = 0,
    parameter int read_latency = 1,
    parameter int init_clear   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_en,
    input  logic                      a_we,
    input  logic [data_width/8-1:0]   a_be,
    input  logic [addr_width-1:0]     a_addr,
    input  logic [data_width-1:0]     a_wdata,
    output logic [data_width-1:0]     a_rdata,
    output logic                      a_rvalid,
    input  logic                      b_en,
    input  logic                      b_we,
    input  logic [data_width/8-1:0]   b_be,
    input  logic [addr_width-1:0]     b_addr,
    input  logic [data_width-1:0]     b_wdata,
    output logic [data_width-1:0]     b_rdata,
    output logic                      b_rvalid,
    output logic                      busy,
    output logic                      collision
);

    localparam int depth = 2 ** addr_width;
    localparam int lanes = data_width / 8;

    typedef enum logic [1:0] {
        IDLE_RST = 2'd0,
        CLEAR    = 2'd1,
        READY    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [addr_width-1:0]   r_clr_cnt;
    logic                    w_clr_last;
    logic                    w_busy;

    logic [data_width-1:0]   r_mem [depth];

    logic                    w_a_acc, w_b_acc;
    logic                    w_a_wr, w_b_wr;
    logic                    w_same_addr;
    logic [data_width-1:0]   w_a_old, w_b_old;
    logic [data_width-1:0]   w_a_new, w_b_new;
    logic [data_width-1:0]   w_a_ret, w_b_ret;

    logic                    r_a_v1, r_b_v1;
    logic [data_width-1:0]   r_a_d1, r_b_d1;
    logic                    r_collision;

    // Lane-wise merge of up to two writes onto one word; port A wins overlapping lanes.
    function automatic logic [data_width-1:0] f_merge(
        input logic [data_width-1:0] old_word,
        input logic                  a_hit,
        input logic [lanes-1:0]      a_lanes,
        input logic [data_width-1:0] a_data,
        input logic                  b_hit,
        input logic [lanes-1:0]      b_lanes,
        input logic [data_width-1:0] b_data
    );
        logic [data_width-1:0] res;
        res = old_word;
        for (int i = 0; i < lanes; i++) begin
            if (b_hit && b_lanes[i]) res[8*i +: 8] = b_data[8*i +: 8];
            if (a_hit && a_lanes[i]) res[8*i +: 8] = a_data[8*i +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE_RST;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
            else                  r_clr_cnt <= '0;
        end
    end

    assign w_clr_last = (r_clr_cnt == {addr_width{1'b1}});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE_RST: w_state_nxt = (init_clear != 0) ? CLEAR : READY;
            CLEAR:    if (w_clr_last) w_state_nxt = READY;
            READY:    w_state_nxt = READY;
            default:  w_state_nxt = IDLE_RST;
        endcase
    end

    assign w_busy = (r_state == CLEAR) || ((r_state == IDLE_RST) && (init_clear != 0));
    assign busy   = w_busy;

    // Requests during reset are ignored as well, so a port cannot disturb memory then.
    assign w_a_acc     = a_en && !w_busy && rst_n;
    assign w_b_acc     = b_en && !w_busy && rst_n;
    assign w_a_wr      = w_a_acc && a_we;
    assign w_b_wr      = w_b_acc && b_we;
    assign w_same_addr = (a_addr == b_addr);

    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    assign w_a_new = f_merge(w_a_old, w_a_wr, a_be, a_wdata,
                             w_b_wr && w_same_addr, b_be, b_wdata);
    assign w_b_new = f_merge(w_b_old, w_a_wr && w_same_addr, a_be, a_wdata,
                             w_b_wr, b_be, b_wdata);

    assign w_a_ret = (rd_mode == 1) ? w_a_new : w_a_old;
    assign w_b_ret = (rd_mode == 1) ? w_b_new : w_b_old;

    // On a same-address double write both ports store the identical merged word.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == CLEAR)) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            if (w_a_wr) r_mem[a_addr] <= w_a_new;
            if (w_b_wr) r_mem[b_addr] <= w_b_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_v1      <= 1'b0;
            r_b_v1      <= 1'b0;
            r_a_d1      <= '0;
            r_b_d1      <= '0;
            r_collision <= 1'b0;
        end else begin
            r_a_v1 <= w_a_acc;
            r_b_v1 <= w_b_acc;
            if (w_a_acc) r_a_d1 <= w_a_ret;
            if (w_b_acc) r_b_d1 <= w_b_ret;
            r_collision <= w_a_wr && w_b_wr && w_same_addr && ((a_be & b_be) != '0);
        end
    end

    assign collision = r_collision;

    generate
        if (read_latency == 2) begin : g_lat2
            logic                  r_a_v2, r_b_v2;
            logic [data_width-1:0] r_a_d2, r_b_d2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_a_v2 <= 1'b0;
                    r_b_v2 <= 1'b0;
                    r_a_d2 <= '0;
                    r_b_d2 <= '0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_b_v2 <= r_b_v1;
                    if (r_a_v1) r_a_d2 <= r_a_d1;
                    if (r_b_v1) r_b_d2 <= r_b_d1;
                end
            end

            assign a_rvalid = r_a_v2;
            assign a_rdata  = r_a_d2;
            assign b_rvalid = r_b_v2;
            assign b_rdata  = r_b_d2;
        end else begin : g_lat1
            assign a_rvalid = r_a_v1;
            assign a_rdata  = r_a_d1;
            assign b_rvalid = r_b_v1;
            assign b_rdata  = r_b_d1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: three instances cover read-first/clear,
// write-first/no-clear and two-cycle latency; all share the same port stimulus.
module tb_dual_port_ram_be;

    logic        clk;
    logic        rst_n;
    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_be, b_be;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1, a_rdata2, b_rdata2;
    logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1, a_rvalid2, b_rvalid2;
    logic        busy0, busy1, busy2;
    logic        coll0, coll1, coll2;

    int total = 0;
    int bad   = 0;

    dual_port_ram_be #(.addr_width(4), .data_width(32), .rd_mode(0),
                       .read_latency(1), .init_clear(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
        .busy(busy0), .collision(coll0));

    dual_port_ram_be #(.addr_width(4), .data_width(32), .rd_mode(1),
                       .read_latency(1), .init_clear(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .busy(busy1), .collision(coll1));

    dual_port_ram_be #(.addr_width(4), .data_width(32), .rd_mode(0),
                       .read_latency(2), .init_clear(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata2), .b_rvalid(b_rvalid2),
        .busy(busy2), .collision(coll2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        a_en = 0; a_we = 0; a_be = 4'h0; a_addr = 4'h0; a_wdata = 32'h0;
        b_en = 0; b_we = 0; b_be = 4'h0; b_addr = 4'h0; b_wdata = 32'h0;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        a_en = 1; a_we = 1; a_addr = addr; a_wdata = data; a_be = be;
    endtask

    task automatic test_reset();
        step();
        total++;
        if ({a_rdata0, b_rdata0, a_rvalid0, b_rvalid0, coll0} !== 67'h0) begin
            bad++;
            $display("FAIL reset_outputs_u0: got a=%h b=%h av=%b bv=%b c=%b want all zero",
                     a_rdata0, b_rdata0, a_rvalid0, b_rvalid0, coll0);
        end
        total++;
        if ({a_rvalid2, b_rvalid2, a_rdata2, b_rdata2} !== 66'h0) begin
            bad++;
            $display("FAIL reset_outputs_u2: got av=%b bv=%b a=%h b=%h want all zero",
                     a_rvalid2, b_rvalid2, a_rdata2, b_rdata2);
        end
        total++;
        if ({busy0, busy1, busy2} !== 3'b101) begin
            bad++;
            $display("FAIL reset_busy: got %b want 101", {busy0, busy1, busy2});
        end
    endtask

    task automatic test_clear();
        int n0, n2;
        logic ok;
        n0 = 0; n2 = 0;
        rst_n = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (busy0) n0++;
            if (busy2) n2++;
            if (!busy0 && !busy2) break;
        end
        total++;
        if (n0 != 16) begin
            bad++;
            $display("FAIL clear_busy_cycles_u0: got %0d want 16", n0);
        end
        total++;
        if (n2 != 16) begin
            bad++;
            $display("FAIL clear_busy_cycles_u2: got %0d want 16", n2);
        end
        total++;
        if (busy1 !== 1'b0) begin
            bad++;
            $display("FAIL noclear_busy: got %b want 0", busy1);
        end
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_en = 1; a_we = 0; a_addr = 4'(i);
            step();
            total++;
            if ({a_rvalid0, a_rdata0} !== 33'h1_0000_0000) begin
                bad++; ok = 1'b0;
                $display("FAIL clear_read_%0d: got v=%b d=%h want v=1 d=00000000",
                         i, a_rvalid0, a_rdata0);
            end
        end
        idle_ports();
        step();
        total++;
        if (a_rvalid0 !== 1'b0) begin
            bad++;
            $display("FAIL rvalid_drop: got %b want 0", a_rvalid0);
        end
    endtask

    task automatic test_byte_enable();
        a_write(4'd5, 32'h1122_3344, 4'b1111);
        step();
        total++;
        if ({a_rvalid0, a_rdata0, a_rdata1} !== {1'b1, 32'h0, 32'h1122_3344}) begin
            bad++;
            $display("FAIL be_write1_return: got v=%b u0=%h u1=%h want 1 00000000 11223344",
                     a_rvalid0, a_rdata0, a_rdata1);
        end
        a_write(4'd5, 32'hAABB_CCDD, 4'b0101);
        step();
        total++;
        if ({a_rdata0, a_rdata1} !== {32'h1122_3344, 32'h11BB_33DD}) begin
            bad++;
            $display("FAIL be_write2_return: got u0=%h u1=%h want 11223344 11BB33DD",
                     a_rdata0, a_rdata1);
        end
        a_write(4'd5, 32'hFFFF_FFFF, 4'b0000);
        step();
        a_en = 1; a_we = 0; a_addr = 4'd5;
        step();
        total++;
        if ({a_rvalid0, a_rdata0} !== {1'b1, 32'h11BB_33DD}) begin
            bad++;
            $display("FAIL be_readback: got v=%b d=%h want 1 11BB33DD", a_rvalid0, a_rdata0);
        end
        idle_ports();
    endtask

    task automatic test_cross_port();
        a_write(4'd7, 32'h0, 4'b1111);
        step();
        a_write(4'd7, 32'hCAFE_F00D, 4'b1111);
        b_en = 1; b_we = 0; b_addr = 4'd7;
        step();
        total++;
        if ({b_rvalid0, b_rdata0} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL cross_read_first: got v=%b d=%h want 1 00000000", b_rvalid0, b_rdata0);
        end
        total++;
        if ({b_rvalid1, b_rdata1} !== {1'b1, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL cross_write_first: got v=%b d=%h want 1 CAFEF00D", b_rvalid1, b_rdata1);
        end
        idle_ports();
        step();
    endtask

    task automatic test_collision();
        a_write(4'd3, 32'h0, 4'b1111);
        step();
        a_write(4'd3, 32'h1111_1111, 4'b0011);
        b_en = 1; b_we = 1; b_addr = 4'd3; b_wdata = 32'h2222_2222; b_be = 4'b0110;
        step();
        total++;
        if ({coll0, coll1, coll2} !== 3'b111) begin
            bad++;
            $display("FAIL collision_pulse: got %b want 111", {coll0, coll1, coll2});
        end
        total++;
        if ({a_rdata1, b_rdata1} !== {32'h0022_1111, 32'h0022_1111}) begin
            bad++;
            $display("FAIL collision_merge_return: got a=%h b=%h want 00221111 both",
                     a_rdata1, b_rdata1);
        end
        idle_ports();
        a_en = 1; a_we = 0; a_addr = 4'd3;
        step();
        total++;
        if ({coll0, a_rdata0} !== {1'b0, 32'h0022_1111}) begin
            bad++;
            $display("FAIL collision_readback: got c=%b d=%h want 0 00221111", coll0, a_rdata0);
        end
        a_write(4'd3, 32'h3333_3333, 4'b0011);
        b_en = 1; b_we = 1; b_addr = 4'd3; b_wdata = 32'h4444_4444; b_be = 4'b1100;
        step();
        total++;
        if ({coll0, b_rdata1} !== {1'b0, 32'h4444_3333}) begin
            bad++;
            $display("FAIL disjoint_lanes: got c=%b d=%h want 0 44443333", coll0, b_rdata1);
        end
        a_write(4'd8, 32'h5555_5555, 4'b1111);
        b_addr = 4'd9; b_be = 4'b1111;
        step();
        total++;
        if (coll0 !== 1'b0) begin
            bad++;
            $display("FAIL diff_addr_collision: got %b want 0", coll0);
        end
        idle_ports();
        step();
    endtask

    task automatic test_back_to_back();
        logic        ev;
        logic [31:0] ed;
        for (int i = 0; i < 4; i++) begin
            a_write(4'(i), 32'hA000_0000 + 32'(i), 4'b1111);
            step();
        end
        idle_ports();
        step();
        step();
        ed = 32'h0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin b_en = 1; b_we = 0; b_addr = 4'(k); end
            else       b_en = 0;
            step();
            ev = (k >= 1 && k <= 4);
            if (ev) ed = 32'hA000_0000 + 32'(k - 1);
            total++;
            if (b_rvalid2 !== ev || (k >= 1 && b_rdata2 !== ed)) begin
                bad++;
                $display("FAIL lat2_cycle_%0d: got v=%b d=%h want v=%b d=%h",
                         k, b_rvalid2, b_rdata2, ev, ed);
            end
        end
        idle_ports();
    endtask

    task automatic test_reset_mid_clear();
        int   n0;
        logic leaked;
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (10) step();
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL midclear_busy: got %b want 1", busy0);
        end
        rst_n = 0;
        a_write(4'd2, 32'hDEAD_BEEF, 4'b1111);
        step();
        rst_n = 1;
        n0 = 0; leaked = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (a_rvalid0) leaked = 1'b1;
            if (busy0) n0++;
            else break;
        end
        idle_ports();
        total++;
        if (n0 != 16) begin
            bad++;
            $display("FAIL restart_busy_cycles: got %0d want 16", n0);
        end
        total++;
        if (leaked !== 1'b0) begin
            bad++;
            $display("FAIL busy_rvalid: got %b want 0", leaked);
        end
        a_en = 1; a_we = 0; a_addr = 4'd2;
        step();
        total++;
        if ({a_rvalid0, a_rdata0} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL busy_write_dropped: got v=%b d=%h want 1 00000000",
                     a_rvalid0, a_rdata0);
        end
        a_addr = 4'd1;
        step();
        total++;
        if (a_rdata0 !== 32'h0) begin
            bad++;
            $display("FAIL restart_cleared_addr1: got %h want 00000000", a_rdata0);
        end
        idle_ports();
        step();
    endtask

    initial begin
        rst_n = 0;
        idle_ports();
        for (int i = 0; i < 16; i++) begin
            u0.r_mem[i] = 32'hFFFF_FFFF;
            u2.r_mem[i] = 32'hFFFF_FFFF;
        end
        step();
        step();
        test_reset();
        test_clear();
        test_byte_enable();
        test_cross_port();
        test_collision();
        test_back_to_back();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Parametrised true dual-port word RAM; next generation of the UART/CNN shared buffer.
- Port A serves the UART loader; port B serves the CNN datapath.
- Adds over the previous RAM: byte-lane write enables, selectable read-during-write mode, 1- or 2-cycle read latency with a valid strobe, deterministic same-address write collision resolution, and a post-reset memory clear sequencer.

Parameters:
- addr_width, 10, word-address width; depth = 2**addr_width words.
- data_width, 32, word width; must be a multiple of 8.
- rd_mode, 0, read-during-write mode. 0 = read-first (old data returned); 1 = write-first (merged new data returned).
- read_latency, 1, cycles from accepted access to rdata/rvalid; legal values are 1 or 2.
- init_clear, 1, when 1 every word is written to zero after reset release.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a_en  input  1  port A access request.
- a_we  input  1  port A write (valid only with a_en).
- a_be  input  data_width/8  port A byte-lane write enables.
- a_addr  input  addr_width  port A word address.
- a_wdata  input  data_width  port A write data.
- a_rdata  output  data_width  port A read data.
- a_rvalid  output  1  port A read data valid, 1-cycle pulse.
- b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid  same widths and meanings for port B.
- busy  output  1  clear sequencer active; all port requests ignored while high.
- collision  output  1  1-cycle pulse: both ports wrote the same address with overlapping byte lanes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - a_rdata = b_rdata = 0; a_rvalid = b_rvalid = 0; collision = 0.
  - All read pipeline stages cleared.
  - busy = init_clear.
  - Memory contents are not reset.
- Clear FSM, states IDLE_RST -> CLEAR -> READY:
  - With init_clear=1, the first edge with rst_n=1 enters CLEAR, counter = 0.
  - CLEAR writes 0 to mem[counter] each cycle and increments the counter.
  - After writing depth-1, the next edge enters READY and busy drops. Exactly depth CLEAR cycles.
  - With init_clear=0, the FSM goes straight to READY and busy stays 0.
  - rst_n low in any state returns to IDLE_RST. A mid-clear reset restarts the clear from address 0.
- Access acceptance:
  - An access is accepted when x_en=1 and busy=0; otherwise it is dropped with no write and no rvalid.
- Writes:
  - For each lane i with x_be[i]=1, mem[addr][8i+7:8i] takes wdata[8i+7:8i].
  - Lanes with be=0 are unchanged. be=0 with we=1 writes nothing.
- Read data return:
  - Every accepted access (read or write) returns data: rdata/rvalid appear read_latency cycles after the accept edge.
  - rvalid is high for exactly one cycle per access. Back-to-back accesses give back-to-back rvalid.
  - rdata holds its last value when rvalid=0.
  - With read_latency=2, the second stage is a plain register; no extra stalls.
- Same-port read-during-write:
  - rd_mode=0 returns pre-write word.
  - rd_mode=1 returns post-write merged word.
- Cross-port, one port writes address X while the other accesses X in the same cycle:
  - rd_mode=0: the other port reads the old word.
  - rd_mode=1: the other port reads the merged new word, including the collision resolution below.
- Both ports write X in the same cycle:
  - Port A wins on overlapping lanes; port B's non-overlapping lanes are written.
  - collision pulses one cycle after the write edge only if (a_be & b_be) != 0.
  - Different addresses never collide.
- Addresses are always in range (depth = 2**addr_width); no wrap logic is needed.

Test Plan:
- init_clear=1, addr_width=4: preload mem via backdoor with 0xFFFFFFFF, release rst_n -> busy high exactly 16 cycles; afterwards reads of all 16 addresses return 0 with a_rvalid 1 cycle (latency 1) after each request.
- Port A write addr 5 data 0x11223344 be=4'b1111, then write addr 5 data 0xAABBCCDD be=4'b0101, then read -> 0x11BB33DD.
- rd_mode=0: mem[7]=0x0; same cycle A writes 0xCAFEF00D to 7 and B reads 7 -> b_rdata=0x00000000. Repeat with rd_mode=1 -> 0xCAFEF00D.
- Same cycle A writes 0x11111111 be=0011 and B writes 0x22222222 be=0110 to addr 3 -> collision pulse next cycle; mem[3]=0x00221111 (from prior 0).
- read_latency=2: reads on port B every cycle to addrs 0..3 -> b_rvalid high 4 consecutive cycles starting 2 cycles after the first request, data in order.
- Assert rst_n low at clear counter 9, release -> clear restarts at 0, busy high a full depth cycles; any a_en during busy produces no rvalid and no write.
